// File: rtl/exec_alias_guard_if.sv
// Store/ITLB-fill bundle for exec_alias_guard.
// EXEC_ALIAS_GUARD_VIOL_CNT_EN adds the viol_cnt observation port.
interface exec_alias_guard_if #(
  parameter int unsigned PPN_W = 20
);
  logic              clear_i;
  logic              insert_i;
  logic [PPN_W-1:0]  insert_ppn;
  logic              write_valid;
  logic              write_en;
  logic [PPN_W+11:0] write_addr;
  logic              lock_i;
  logic              allow_override_prelock;
  logic              hit_exec_ppn;
  logic              allow_write;
  logic              violation_o;
`ifdef EXEC_ALIAS_GUARD_VIOL_CNT_EN
  logic [15:0]       viol_cnt;

  modport master (
    output clear_i, insert_i, insert_ppn, write_valid, write_en, write_addr,
           lock_i, allow_override_prelock,
    input  hit_exec_ppn, allow_write, violation_o, viol_cnt
  );

  modport slave (
    input  clear_i, insert_i, insert_ppn, write_valid, write_en, write_addr,
           lock_i, allow_override_prelock,
    output hit_exec_ppn, allow_write, violation_o, viol_cnt
  );
`else
  modport master (
    output clear_i, insert_i, insert_ppn, write_valid, write_en, write_addr,
           lock_i, allow_override_prelock,
    input  hit_exec_ppn, allow_write, violation_o
  );

  modport slave (
    input  clear_i, insert_i, insert_ppn, write_valid, write_en, write_addr,
           lock_i, allow_override_prelock,
    output hit_exec_ppn, allow_write, violation_o
  );
`endif
endinterface

// File: rtl/exec_alias_guard.sv
// Blocks stores that alias a recently executable page (W^X guard with boot-time override).
// Optional EXEC_ALIAS_GUARD_VIOL_CNT_EN adds a saturating 16-bit violation counter.
module exec_alias_guard #(
  parameter int unsigned PPN_W = 20,
  parameter int unsigned N     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  exec_alias_guard_if.slave  bus
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     valid_q;
  logic [PPN_W-1:0] ppn_q [N];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_nxt;
  logic             viol_q;

  logic [PPN_W-1:0] query_ppn;
  logic [N-1:0]     hit_vec;
  logic [N-1:0]     dup_vec;
  logic             hit;
  logic             allow;
  logic             ins_fire;
  logic             viol_d;
  logic             unused_offset;

  // Page offset never participates in the match.
  assign query_ppn     = bus.write_addr[PPN_W+11:12];
  assign unused_offset = ^bus.write_addr[11:0];

  // Per-entry compare against the store page and the fill page.
  always_comb begin
    hit_vec = '0;
    dup_vec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hit_vec[i] = valid_q[i] && (ppn_q[i] == query_ppn);
      dup_vec[i] = valid_q[i] && (ppn_q[i] == bus.insert_ppn);
    end
  end

  assign hit      = |hit_vec;
  assign allow    = !hit || (!bus.lock_i && bus.allow_override_prelock);
  assign ins_fire = bus.insert_i && !bus.clear_i && !(|dup_vec);
  assign ptr_nxt  = (ptr_q == PTR_W'(N - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign viol_d   = bus.write_valid && bus.write_en && !allow;

  // Round-robin tracker; clear beats a simultaneous fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ptr_q   <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        ppn_q[i] <= '0;
      end
    end else if (bus.clear_i) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (ins_fire) begin
      valid_q[ptr_q] <= 1'b1;
      ppn_q[ptr_q]   <= bus.insert_ppn;
      ptr_q          <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_q <= 1'b0;
    end else begin
      viol_q <= viol_d;
    end
  end

  assign bus.hit_exec_ppn = hit;
  assign bus.allow_write  = allow;
  assign bus.violation_o  = viol_q;

`ifdef EXEC_ALIAS_GUARD_VIOL_CNT_EN
  logic [15:0] cnt_q;

  // Counts violation pulses; only software before lock may wipe it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.clear_i && !bus.lock_i) begin
      cnt_q <= '0;
    end else if (viol_q && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.viol_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_exec_alias_guard.sv
// Scoreboard bench for exec_alias_guard: directed stimulus queues expectations, a negedge monitor checks them.
module tb_exec_alias_guard;

  localparam int unsigned PPN_W = 20;
  localparam int unsigned N     = 8;

  localparam int SIG_HIT = 0;
  localparam int SIG_ALW = 1;
  localparam int SIG_VIO = 2;
  localparam int SIG_CNT = 3;

  typedef struct {
    string       name;
    int          sig;
    logic [15:0] val;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   passed;
  int   total;
  exp_t sb[$];

  exec_alias_guard_if #(.PPN_W(PPN_W)) bus ();

  exec_alias_guard #(.PPN_W(PPN_W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] actual(int s);
    case (s)
      SIG_HIT: return 16'(bus.hit_exec_ppn);
      SIG_ALW: return 16'(bus.allow_write);
      SIG_VIO: return 16'(bus.violation_o);
`ifdef EXEC_ALIAS_GUARD_VIOL_CNT_EN
      SIG_CNT: return bus.viol_cnt;
`endif
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic expect_at(string n, int s, logic [15:0] v, int d);
    exp_t e;
    e.name = n;
    e.sig  = s;
    e.val  = v;
    e.due  = d;
    sb.push_back(e);
  endtask

  // Monitor: retire every expectation whose cycle has come.
  always @(negedge clk) begin
    int i;
    logic [15:0] a;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        a = actual(sb[i].sig);
        total = total + 1;
        if (a === sb[i].val) passed = passed + 1;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", sb[i].name, a, sb[i].val, cyc);
        sb.delete(i);
      end else begin
        i = i + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.clear_i     = 1'b0;
    bus.insert_i    = 1'b0;
    bus.write_valid = 1'b0;
    bus.write_en    = 1'b0;
  endtask

  task automatic store(logic [31:0] a);
    bus.write_addr  = a;
    bus.write_valid = 1'b1;
    bus.write_en    = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    idle();
    bus.lock_i                 = 1'b1;
    bus.allow_override_prelock = 1'b0;
    bus.insert_ppn             = '0;
    bus.write_addr             = '0;

    // Reset state, even with a store presented.
    tick();
    store(32'h0800_4000);
    expect_at("rst_hit", SIG_HIT, 16'd0, cyc);
    expect_at("rst_allow", SIG_ALW, 16'd1, cyc);
    expect_at("rst_viol", SIG_VIO, 16'd0, cyc);
`ifdef EXEC_ALIAS_GUARD_VIOL_CNT_EN
    expect_at("rst_cnt", SIG_CNT, 16'd0, cyc);
`endif
    #1;
    total = total + 1;
    if (bus.allow_write === 1'b1 && bus.hit_exec_ppn === 1'b0) passed = passed + 1;
    else $display("FAIL rst_direct: got hit=%b allow=%b expected hit=0 allow=1", bus.hit_exec_ppn, bus.allow_write);
    tick();
    rst_n = 1'b1;
    idle();

    tick();
    store(32'h0800_4000);
    expect_at("empty_hit", SIG_HIT, 16'd0, cyc);
    expect_at("empty_allow", SIG_ALW, 16'd1, cyc);
    expect_at("empty_viol", SIG_VIO, 16'd0, cyc + 1);

    // Fill is not visible in its own cycle.
    tick();
    idle();
    bus.insert_i   = 1'b1;
    bus.insert_ppn = 20'h08004;
    bus.write_addr = 32'h0800_4000;
    expect_at("ins_same_cycle", SIG_HIT, 16'd0, cyc);

    tick();
    idle();
    store(32'h0800_4010);
    expect_at("exec_hit", SIG_HIT, 16'd1, cyc);
    expect_at("exec_block", SIG_ALW, 16'd0, cyc);
    expect_at("viol_pulse", SIG_VIO, 16'd1, cyc + 1);
    #1;
    total = total + 1;
    if (bus.hit_exec_ppn === 1'b1 && bus.allow_write === 1'b0) passed = passed + 1;
    else $display("FAIL exec_direct: got hit=%b allow=%b expected hit=1 allow=0", bus.hit_exec_ppn, bus.allow_write);

    tick();
    idle();
    expect_at("viol_one_cycle", SIG_VIO, 16'd0, cyc + 1);

    tick();
    bus.lock_i                 = 1'b0;
    bus.allow_override_prelock = 1'b1;
    store(32'h0800_4020);
    expect_at("ovr_hit", SIG_HIT, 16'd1, cyc);
    expect_at("ovr_allow", SIG_ALW, 16'd1, cyc);
    expect_at("ovr_no_viol", SIG_VIO, 16'd0, cyc + 1);

    tick();
    bus.allow_override_prelock = 1'b0;
    store(32'h0800_4020);
    expect_at("prelock_no_ovr", SIG_ALW, 16'd0, cyc);
    expect_at("prelock_viol", SIG_VIO, 16'd1, cyc + 1);

    tick();
    bus.lock_i                 = 1'b1;
    bus.allow_override_prelock = 1'b1;
    store(32'h0800_4030);
    expect_at("lock_ignores_ovr", SIG_ALW, 16'd0, cyc);
    expect_at("lock_viol", SIG_VIO, 16'd1, cyc + 1);

    tick();
    idle();
    bus.lock_i                 = 1'b0;
    bus.allow_override_prelock = 1'b0;
    bus.clear_i                = 1'b1;

    tick();
    idle();
    bus.lock_i = 1'b1;
    store(32'h0800_4040);
    expect_at("clr_hit", SIG_HIT, 16'd0, cyc);
    expect_at("clr_allow", SIG_ALW, 16'd1, cyc);
    expect_at("clr_no_viol", SIG_VIO, 16'd0, cyc + 1);
`ifdef EXEC_ALIAS_GUARD_VIOL_CNT_EN
    expect_at("clr_cnt_unlocked", SIG_CNT, 16'd0, cyc);
`endif
    #1;
    total = total + 1;
    if (bus.hit_exec_ppn === 1'b0 && bus.allow_write === 1'b1) passed = passed + 1;
    else $display("FAIL clr_direct: got hit=%b allow=%b expected hit=0 allow=1", bus.hit_exec_ppn, bus.allow_write);

    tick();
    idle();
    bus.clear_i    = 1'b1;
    bus.insert_i   = 1'b1;
    bus.insert_ppn = 20'h08004;

    tick();
    idle();
    bus.write_addr = 32'h0800_4000;
    expect_at("clr_wins", SIG_HIT, 16'd0, cyc);

    // N+1 fills: the oldest entry is overwritten.
    for (int k = 1; k <= 9; k++) begin
      tick();
      idle();
      bus.insert_i   = 1'b1;
      bus.insert_ppn = 20'(k);
    end
    tick();
    idle();
    bus.write_addr = 32'h0000_1000;
    expect_at("wrap_oldest_gone", SIG_HIT, 16'd0, cyc);
    for (int k = 2; k <= 9; k++) begin
      tick();
      bus.write_addr = 32'(k) << 12;
      expect_at($sformatf("wrap_hit_%0d", k), SIG_HIT, 16'd1, cyc);
    end

    // Duplicate fill must not move the pointer: 0xA then lands on 0x2's slot.
    tick();
    bus.insert_i   = 1'b1;
    bus.insert_ppn = 20'h00005;
    tick();
    bus.insert_ppn = 20'h0000A;
    tick();
    idle();
    bus.write_addr = 32'h0000_A000;
    expect_at("new_after_dup", SIG_HIT, 16'd1, cyc);
    tick();
    bus.write_addr = 32'h0000_3000;
    expect_at("dup_ptr_kept", SIG_HIT, 16'd1, cyc);
    tick();
    bus.write_addr = 32'h0000_2000;
    expect_at("dup_evicts_next", SIG_HIT, 16'd0, cyc);
    tick();
    bus.write_addr = 32'h0000_5000;
    expect_at("dup_still_hit", SIG_HIT, 16'd1, cyc);

`ifdef EXEC_ALIAS_GUARD_VIOL_CNT_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      store(32'h0000_3008);
      expect_at($sformatf("cnt_viol_%0d", k), SIG_VIO, 16'd1, cyc + 1);
    end
    tick();
    idle();
    tick();
    expect_at("cnt_three", SIG_CNT, 16'd3, cyc);
    tick();
    bus.lock_i  = 1'b1;
    bus.clear_i = 1'b1;
    tick();
    idle();
    expect_at("cnt_locked_clear", SIG_CNT, 16'd3, cyc);
    for (int k = 1; k <= 3; k++) begin
      tick();
      bus.insert_i   = 1'b1;
      bus.insert_ppn = 20'(k);
    end
    tick();
    idle();
    store(32'h0000_1000);
    expect_at("cnt_refill_viol", SIG_VIO, 16'd1, cyc + 1);
    tick();
    idle();
    bus.write_addr = 32'h0000_1000;
`else
    tick();
    idle();
    bus.write_addr = 32'h0000_5000;
`endif

    // Asynchronous reset mid-operation drops tracked pages before the next edge.
    tick();
    rst_n = 1'b0;
    expect_at("async_rst_hit", SIG_HIT, 16'd0, cyc);
    expect_at("async_rst_allow", SIG_ALW, 16'd1, cyc);
    expect_at("async_rst_viol", SIG_VIO, 16'd0, cyc);
`ifdef EXEC_ALIAS_GUARD_VIOL_CNT_EN
    expect_at("async_rst_cnt", SIG_CNT, 16'd0, cyc);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    expect_at("post_rst_hit", SIG_HIT, 16'd0, cyc);
    #1;
    total = total + 1;
    if (bus.hit_exec_ppn === 1'b0 && bus.violation_o === 1'b0) passed = passed + 1;
    else $display("FAIL post_rst_direct: got hit=%b viol=%b expected hit=0 viol=0", bus.hit_exec_ppn, bus.violation_o);

    for (int w = 0; w < 10 && sb.size() > 0; w++) tick();
    while (sb.size() > 0) begin
      total = total + 1;
      $display("FAIL %s: got unchecked expected checked by cycle %0d", sb[0].name, sb[0].due);
      void'(sb.pop_front());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
